smplfir_chan_arb: RTL and testbench
===================================

Name: smplfir_chan_arb

Overview:
- Time-shares one two-tap [1,1] FIR sum (o = x[n] + x[n-1]) across NCH independent input channels.
- Each channel keeps its own previous sample, so every channel sees a private [1,1] filter over its own sample stream.
- A round-robin arbiter grants one channel per clock onto a single registered output stream tagged with the channel index.
- Sits between multi-channel sample sources and one downstream consumer with valid/ready flow control.

Parameters:
- IW, 15, input sample width in bits (unsigned)
- NCH, 4, number of channels (2..16)
- LGNCH, 2, width of the channel index; must equal ceil(log2(NCH))

Ports:
- i_clk  input  1  system clock; all state changes on its rising edge
- i_reset_n  input  1  asynchronous active-low reset
- i_clear  input  1  synchronous clear of all channel histories and the arbiter pointer
- i_valid  input  NCH  per-channel sample valid
- i_data  input  NCH*IW  channel c sample on bits [c*IW +: IW]
- o_ready  output  NCH  per-channel accept; one-hot or zero, combinational
- o_valid  output  1  output sample valid
- o_chan  output  LGNCH  channel index of o_data
- o_data  output  IW+1  filtered sum
- i_ready  input  1  downstream accepts the output

Behaviour:
- Reset (i_reset_n low, asynchronous): all histories = 0, o_valid = 0, o_chan = 0, o_data = 0, rr pointer = NCH-1 (channel 0 has highest priority next).
- Slot free: slot_free = !o_valid || i_ready.
- Grant: when slot_free && !i_clear && |i_valid, grant the first valid channel searching upward from pointer+1 modulo NCH; o_ready = one-hot(grant), else 0.
  - o_ready must not depend on i_data.
  - o_ready may depend on i_ready combinationally.
- Transfer: a sample transfers for channel c iff i_valid[c] && o_ready[c].
- On transfer of channel c, next clock:
  - o_data = {1'b0,x} + {1'b0,hist[c]}, unsigned, IW+1 bits, no overflow possible.
  - o_chan = c; o_valid = 1; hist[c] = x; pointer = c.
  - Latency: 1 clock from transfer to o_valid.
- No transfer, slot_free: o_valid = 0 next clock; o_data/o_chan hold their last values.
- Backpressure (o_valid && !i_ready): o_valid/o_data/o_chan hold stable, o_ready = 0, no history change.
- Simultaneous drain and accept (o_valid && i_ready && a request present): the new transfer is allowed in the same cycle; full throughput is 1 sample/clock.
- i_clear high: all hist = 0; pointer = NCH-1; o_ready = 0 (no transfer that cycle).
  - The output register is unaffected; a pending o_valid still drains normally through i_ready.
- Fairness: with all channels continuously valid and i_ready = 1, grants cycle 0,1,...,NCH-1,0...; no channel waits more than NCH-1 grants.
- First sample of a channel after reset or clear: output equals the sample (hist = 0).
- Non-contiguous requests: the pointer skips idle channels; the wrap from NCH-1 to 0 is seamless.
- Reset asserted mid-stream: outputs drop to their reset values immediately; in-flight output and histories are lost.

Test Plan:
- Reset, single channel: ch1 sends 5, then 7, i_ready=1 -> o_valid outputs (chan1, 5) then (chan1, 12), each 1 clock after its transfer.
- All 4 channels valid continuously, ch c sends constant 10*c+1, i_ready=1 -> grant order 0,1,2,3,0,...
  - First round: 1, 11, 21, 31.
  - Subsequent rounds: 2, 22, 42, 62.
- Backpressure: hold i_ready=0 for 3 clocks while o_valid=1 with o_data 12 -> o_data and o_chan stable, o_ready=0.
  - Then i_ready=1 with ch2 valid -> ch2 accepted in that same cycle.
- Overflow width: ch0 sends 0x7FFF twice (IW=15) -> second output 0xFFFE on 16 bits, no wrap.
- Clear: after ch3 history = 9, pulse i_clear with ch3 valid -> no accept that cycle.
  - Next accept of ch3 with value 4 -> output 4.
  - Grant restarts from channel 0.
- Async reset mid-burst: drop i_reset_n between clock edges with o_valid=1 -> o_valid=0, o_data=0 immediately.
  - After release, the first sample per channel passes through unchanged.

Source files
------------

// File: rtl/smplfir_chan_arb.sv
// smplfir_chan_arb: one shared two-tap [1,1] FIR (x[n] + x[n-1]) time-shared across NCH
// channels. A round-robin arbiter picks one channel per clock. Each channel keeps its own
// previous sample. The result leaves on a registered valid/ready stream tagged with the
// channel index.
module smplfir_chan_arb #(
  parameter int unsigned IW    = 15,
  parameter int unsigned NCH   = 4,
  parameter int unsigned LGNCH = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clear,
  input  logic [NCH-1:0]    i_valid,
  input  logic [NCH*IW-1:0] i_data,
  output logic [NCH-1:0]    o_ready,
  output logic              o_valid,
  output logic [LGNCH-1:0]  o_chan,
  output logic [IW:0]       o_data,
  input  logic              i_ready
);

  logic [IW-1:0]    hist_q [NCH];
  logic [LGNCH-1:0] ptr_q;
  logic             valid_q;
  logic [LGNCH-1:0] chan_q;
  logic [IW:0]      data_q;

  logic             slot_free;
  logic             grant_vld;
  logic [LGNCH-1:0] grant_idx;
  logic             accept;
  logic [IW-1:0]    x;
  logic [IW:0]      sum;

  // The output slot can take a new sample when it is empty or is being drained this cycle.
  assign slot_free = !valid_q || i_ready;

  // Round-robin search: take the first valid channel above the last granted one, with wrap.
  always_comb begin
    logic [LGNCH-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      cand = LGNCH'((32'(ptr_q) + k) % NCH);
      if (!grant_vld && i_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign accept  = slot_free && !i_clear && grant_vld;
  assign o_ready = accept ? (NCH'(1) << grant_idx) : '0;

  assign x   = i_data[grant_idx*IW +: IW];
  assign sum = {1'b0, x} + {1'b0, hist_q[grant_idx]};

  // Per-channel history and arbiter pointer; clear wins over any transfer.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned c = 0; c < NCH; c++) hist_q[c] <= '0;
      ptr_q <= LGNCH'(NCH - 1);
    end else if (i_clear) begin
      for (int unsigned c = 0; c < NCH; c++) hist_q[c] <= '0;
      ptr_q <= LGNCH'(NCH - 1);
    end else if (accept) begin
      hist_q[grant_idx] <= x;
      ptr_q             <= grant_idx;
    end
  end

  // Output register: load on transfer, drop valid when drained, hold under backpressure.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q <= 1'b0;
      chan_q  <= '0;
      data_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      chan_q  <= grant_idx;
      data_q  <= sum;
    end else if (slot_free) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid = valid_q;
  assign o_chan  = chan_q;
  assign o_data  = data_q;

endmodule

// File: tb/tb_smplfir_chan_arb.sv
// Self-checking bench for smplfir_chan_arb: directed scenarios plus a randomized run
// against a behavioural model.
module tb_smplfir_chan_arb;

  localparam int unsigned IW    = 15;
  localparam int unsigned NCH   = 4;
  localparam int unsigned LGNCH = 2;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic [NCH-1:0]    valid;
  logic [IW-1:0]     din [NCH];
  logic [NCH*IW-1:0] data_bus;
  logic [NCH-1:0]    o_ready;
  logic              o_valid;
  logic [LGNCH-1:0]  o_chan;
  logic [IW:0]       o_data;
  logic              ready_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_hist [NCH];
  int m_ptr;
  bit m_v;
  int m_d;
  int m_c;
  bit m_known;

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign data_bus[g*IW +: IW] = din[g];
  end

  smplfir_chan_arb #(.IW(IW), .NCH(NCH), .LGNCH(LGNCH)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_clear   (clear),
    .i_valid   (valid),
    .i_data    (data_bus),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_chan    (o_chan),
    .o_data    (o_data),
    .i_ready   (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; valid = '0; ready_in = 1'b1;
    for (int c = 0; c < NCH; c++) din[c] = '0;
    #12;
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", o_valid); end
    n_checks++;
    if (o_data !== '0) begin n_fail++; $display("FAIL reset_data got %0d want 0", o_data); end
    n_checks++;
    if (o_chan !== '0) begin n_fail++; $display("FAIL reset_chan got %0d want 0", o_chan); end
    n_checks++;
    if (o_ready !== '0) begin n_fail++; $display("FAIL reset_ready got %b want 0000", o_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single_channel;
    valid = 4'b0010; din[1] = 15'd5;
    #1;
    n_checks++;
    if (o_ready !== 4'b0010) begin n_fail++; $display("FAIL single_rdy0 got %b want 0010", o_ready); end
    tick;
    n_checks++;
    if (o_valid !== 1'b1 || o_chan !== 2'd1 || o_data !== 16'd5) begin
      n_fail++; $display("FAIL single_out0 got v%0b c%0d d%0d want v1 c1 d5", o_valid, o_chan, o_data);
    end
    din[1] = 15'd7;
    #1;
    n_checks++;
    if (o_ready !== 4'b0010) begin n_fail++; $display("FAIL single_rdy1 got %b want 0010", o_ready); end
    tick;
    n_checks++;
    if (o_valid !== 1'b1 || o_chan !== 2'd1 || o_data !== 16'd12) begin
      n_fail++; $display("FAIL single_out1 got v%0b c%0d d%0d want v1 c1 d12", o_valid, o_chan, o_data);
    end
    valid = '0;
    tick;
    n_checks++;
    if (o_valid !== 1'b0 || o_data !== 16'd12) begin
      n_fail++; $display("FAIL single_idle got v%0b d%0d want v0 d12", o_valid, o_data);
    end
  endtask

  task automatic test_round_robin;
    clear = 1'b1; valid = '0;
    tick;
    clear = 1'b0;
    valid = 4'b1111;
    for (int c = 0; c < NCH; c++) din[c] = IW'(10 * c + 1);
    for (int i = 0; i < 2 * NCH; i++) begin
      int c;
      int exp_d;
      c = i % NCH;
      exp_d = (i < NCH) ? (10 * c + 1) : 2 * (10 * c + 1);
      #1;
      n_checks++;
      if (o_ready !== (4'b0001 << c)) begin
        n_fail++; $display("FAIL rr_grant[%0d] got %b want ch%0d", i, o_ready, c);
      end
      tick;
      n_checks++;
      if (o_valid !== 1'b1 || o_chan !== 2'(c) || o_data !== 16'(exp_d)) begin
        n_fail++;
        $display("FAIL rr_out[%0d] got v%0b c%0d d%0d want v1 c%0d d%0d",
                 i, o_valid, o_chan, o_data, c, exp_d);
      end
    end
    valid = '0;
    tick;
  endtask

  task automatic test_backpressure;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    valid = 4'b0010; din[1] = 15'd5;
    tick;
    din[1] = 15'd7;
    tick;
    ready_in = 1'b0; valid = 4'b0100; din[2] = 15'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (o_ready !== '0 || o_valid !== 1'b1 || o_chan !== 2'd1 || o_data !== 16'd12) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got r%b v%0b c%0d d%0d want r0000 v1 c1 d12",
                 i, o_ready, o_valid, o_chan, o_data);
      end
      tick;
    end
    ready_in = 1'b1;
    #1;
    n_checks++;
    if (o_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release got %b want 0100", o_ready); end
    tick;
    n_checks++;
    if (o_valid !== 1'b1 || o_chan !== 2'd2 || o_data !== 16'd3) begin
      n_fail++; $display("FAIL bp_out got v%0b c%0d d%0d want v1 c2 d3", o_valid, o_chan, o_data);
    end
    valid = '0;
    tick;
  endtask

  task automatic test_overflow;
    valid = 4'b0001; din[0] = 15'h7FFF;
    tick;
    n_checks++;
    if (o_data !== 16'h7FFF || o_chan !== 2'd0) begin
      n_fail++; $display("FAIL ovf_first got c%0d d%h want c0 d7fff", o_chan, o_data);
    end
    tick;
    n_checks++;
    if (o_data !== 16'hFFFE || o_valid !== 1'b1) begin
      n_fail++; $display("FAIL ovf_second got v%0b d%h want v1 dfffe", o_valid, o_data);
    end
    valid = '0;
    tick;
  endtask

  task automatic test_clear;
    valid = 4'b1000; din[3] = 15'd9;
    tick;
    valid = 4'b0010; din[1] = 15'd1;
    tick;
    clear = 1'b1; valid = 4'b1010;
    #1;
    n_checks++;
    if (o_ready !== '0) begin n_fail++; $display("FAIL clr_noacc got %b want 0000", o_ready); end
    tick;
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL clr_drain got v%0b want 0", o_valid); end
    clear = 1'b0; valid = 4'b1001; din[0] = 15'd6; din[3] = 15'd4;
    #1;
    n_checks++;
    if (o_ready !== 4'b0001) begin n_fail++; $display("FAIL clr_restart got %b want 0001", o_ready); end
    tick;
    n_checks++;
    if (o_chan !== 2'd0 || o_data !== 16'd6) begin
      n_fail++; $display("FAIL clr_ch0 got c%0d d%0d want c0 d6", o_chan, o_data);
    end
    valid = 4'b1000;
    tick;
    n_checks++;
    if (o_valid !== 1'b1 || o_chan !== 2'd3 || o_data !== 16'd4) begin
      n_fail++; $display("FAIL clr_ch3 got v%0b c%0d d%0d want v1 c3 d4", o_valid, o_chan, o_data);
    end
    valid = '0;
    tick;
  endtask

  task automatic test_async_reset;
    valid = 4'b0100; din[2] = 15'd8;
    tick;
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 16'd8) begin
      n_fail++; $display("FAIL ar_pre got v%0b d%0d want v1 d8", o_valid, o_data);
    end
    valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_chan !== '0) begin
      n_fail++; $display("FAIL ar_drop got v%0b c%0d d%0d want v0 c0 d0", o_valid, o_chan, o_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    valid = 4'b0101; din[0] = 15'd21; din[2] = 15'd22;
    tick;
    n_checks++;
    if (o_chan !== 2'd0 || o_data !== 16'd21) begin
      n_fail++; $display("FAIL ar_first0 got c%0d d%0d want c0 d21", o_chan, o_data);
    end
    tick;
    n_checks++;
    if (o_chan !== 2'd2 || o_data !== 16'd22) begin
      n_fail++; $display("FAIL ar_first2 got c%0d d%0d want c2 d22", o_chan, o_data);
    end
    valid = '0;
    tick;
  endtask

  task automatic test_random;
    logic [NCH-1:0] v;
    logic [NCH-1:0] exp_rdy;
    int g;
    bit slot;
    bit acc;
    clear = 1'b1; valid = '0; ready_in = 1'b1;
    tick;
    clear = 1'b0;
    tick;
    for (int c = 0; c < NCH; c++) m_hist[c] = 0;
    m_ptr = NCH - 1; m_v = 1'b0; m_known = 1'b0; m_d = 0; m_c = 0;
    for (int n = 0; n < 400; n++) begin
      n_checks++;
      if (o_valid !== m_v) begin
        n_fail++; $display("FAIL rnd_valid[%0d] got %0b want %0b", n, o_valid, m_v);
      end
      if (m_known) begin
        n_checks++;
        if (o_data !== 16'(m_d) || o_chan !== 2'(m_c)) begin
          n_fail++;
          $display("FAIL rnd_out[%0d] got c%0d d%0d want c%0d d%0d", n, o_chan, o_data, m_c, m_d);
        end
      end
      v = NCH'($urandom);
      for (int c = 0; c < NCH; c++) din[c] = IW'($urandom);
      ready_in = ($urandom_range(0, 9) < 7);
      clear    = ($urandom_range(0, 19) == 0);
      valid    = v;
      #1;
      slot = !m_v || ready_in;
      g = -1;
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (m_ptr + k) % NCH;
        if (g < 0 && v[c]) g = c;
      end
      acc = slot && !clear && (g >= 0);
      exp_rdy = acc ? (NCH'(1) << g) : '0;
      n_checks++;
      if (o_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rnd_ready[%0d] got %b want %b", n, o_ready, exp_rdy);
      end
      if (acc) begin
        m_d = int'(din[g]) + m_hist[g];
        m_c = g; m_v = 1'b1; m_known = 1'b1;
      end else if (slot) begin
        m_v = 1'b0;
      end
      if (clear) begin
        for (int c = 0; c < NCH; c++) m_hist[c] = 0;
        m_ptr = NCH - 1;
      end else if (acc) begin
        m_hist[g] = int'(din[g]);
        m_ptr = g;
      end
      tick;
    end
    valid = '0; clear = 1'b0; ready_in = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_clear();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
